// File: rtl/ta_sync_pkg.sv
// ta_sync_pkg: shared definitions for the clk50 sync handshake.
//   - resp_state_t : responder FSM encoding (used by ta_sync_resp)
//   - init_state_t : initiator FSM encoding (capture sync controller side)
//   - SYNC_CNT_W   : width of the completed-sync counter
//   - cnt_width()  : bit width needed to hold values 0..max_val
package ta_sync_pkg;

  localparam int SYNC_CNT_W = 16;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_RDY  = 3'd1,
    S_ACK  = 3'd2,
    S_SET  = 3'd3,
    S_CAP  = 3'd4,
    S_DONE = 3'd5
  } resp_state_t;

  typedef enum logic [1:0] {
    I_IDLE = 2'd0,
    I_TRIG = 2'd1,
    I_WAIT = 2'd2
  } init_state_t;

  // Counters must hold their terminal value plus the one increment that
  // happens on the cycle the terminal count is acted upon.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ta_sync_cnt.sv
// ta_sync_cnt: generic up-counter with synchronous clear, count enable and
// terminal-count compare.
// Ports:
//   clk50  in  1  clock
//   rst    in  1  synchronous active-high reset (count -> 0)
//   clr    in  1  synchronous clear, has priority over en
//   en     in  1  count enable
//   cnt    out W  current count
//   tc     out 1  high while cnt == TC
module ta_sync_cnt #(
  parameter int W  = 8,
  parameter int TC = 255
) (
  input  logic         clk50,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] TC_V = W'(TC);

  // Counter register: reset/clear to zero, otherwise step when enabled.
  always_ff @(posedge clk50) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1'b1);
    end else begin
      cnt <= cnt;
    end
  end

  assign tc = (cnt == TC_V);

endmodule

// File: rtl/ta_sync_resp.sv
// ta_sync_resp: responder end of the clk50 sync handshake.
// On a sync request it drops syncr_rdy, waits for the trigger to be released
// (or times out), settles for SET_DEL cycles, captures CAP_LEN valid samples
// into a write-port buffer from address 0, then re-raises syncr_rdy.
// Ports:
//   clk50      in  1   50 MHz clock
//   rst        in  1   synchronous active-high reset
//   sync_trig  in  1   sync request (level), sampled only while ready
//   syncr_rdy  out 1   responder ready; 0 = request accepted / capturing
//   din_valid  in  1   sample qualifier
//   din        in  DW  sample data
//   wr_en      out 1   buffer write strobe
//   wr_addr    out AW  buffer write address
//   wr_data    out DW  buffer write data
//   cap_done   out 1   one-cycle pulse with the last write
//   tmo_err    out 1   sticky: trigger held past TMO, cleared only by rst
//   sync_cnt   out 16  completed sync cycles (wrapping)
module ta_sync_resp
  import ta_sync_pkg::*;
#(
  parameter int DW      = 16,
  parameter int AW      = 10,
  parameter int CAP_LEN = 1024,
  parameter int SET_DEL = 8,
  parameter int TMO     = 255
) (
  input  logic                  clk50,
  input  logic                  rst,
  input  logic                  sync_trig,
  output logic                  syncr_rdy,
  input  logic                  din_valid,
  input  logic [DW-1:0]         din,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [DW-1:0]         wr_data,
  output logic                  cap_done,
  output logic                  tmo_err,
  output logic [SYNC_CNT_W-1:0] sync_cnt
);

  localparam int TW = cnt_width(TMO);
  localparam int SW = cnt_width(SET_DEL);
  localparam int CW = cnt_width(CAP_LEN);

  resp_state_t     state_r;
  logic [TW-1:0]   tmo_cnt_r;
  logic [SW-1:0]   set_cnt_r;
  logic [CW-1:0]   cap_cnt_r;
  logic            tmo_tc_s;
  logic            set_tc_s;
  logic            cap_tc_s;
  logic            tmo_clr_s;
  logic            tmo_en_s;
  logic            set_clr_s;
  logic            set_en_s;
  logic            cap_clr_s;
  logic            cap_en_s;
  logic            ack_exit_s;

  // The acknowledge phase ends on trigger release or when the trigger has
  // been high for TMO acknowledge cycles; both paths start the settle count.
  assign ack_exit_s = (state_r == S_ACK) && (!sync_trig || tmo_tc_s);

  assign tmo_clr_s  = (state_r == S_RDY) && sync_trig;
  assign tmo_en_s   = (state_r == S_ACK) && sync_trig;
  assign set_clr_s  = ack_exit_s;
  assign set_en_s   = (state_r == S_SET);
  assign cap_clr_s  = (state_r == S_SET) && set_tc_s;
  assign cap_en_s   = (state_r == S_CAP) && din_valid;

  ta_sync_cnt #(.W(TW), .TC(TMO - 1)) u_tmo_cnt (
    .clk50 (clk50),
    .rst   (rst),
    .clr   (tmo_clr_s),
    .en    (tmo_en_s),
    .cnt   (tmo_cnt_r),
    .tc    (tmo_tc_s)
  );

  ta_sync_cnt #(.W(SW), .TC(SET_DEL - 1)) u_set_cnt (
    .clk50 (clk50),
    .rst   (rst),
    .clr   (set_clr_s),
    .en    (set_en_s),
    .cnt   (set_cnt_r),
    .tc    (set_tc_s)
  );

  // cap_cnt is wide enough to count to CAP_LEN, so it never wraps mid-capture.
  ta_sync_cnt #(.W(CW), .TC(CAP_LEN - 1)) u_cap_cnt (
    .clk50 (clk50),
    .rst   (rst),
    .clr   (cap_clr_s),
    .en    (cap_en_s),
    .cnt   (cap_cnt_r),
    .tc    (cap_tc_s)
  );

  // Responder FSM with registered handshake and write-port outputs.
  always_ff @(posedge clk50) begin
    if (rst) begin
      state_r   <= S_INIT;
      syncr_rdy <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cap_done  <= 1'b0;
      tmo_err   <= 1'b0;
      sync_cnt  <= '0;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them below.
      wr_en    <= 1'b0;
      cap_done <= 1'b0;
      case (state_r)
        S_INIT: begin
          syncr_rdy <= 1'b1;
          state_r   <= S_RDY;
        end
        S_RDY: begin
          if (sync_trig) begin
            syncr_rdy <= 1'b0;
            state_r   <= S_ACK;
          end else begin
            state_r   <= S_RDY;
          end
        end
        S_ACK: begin
          if (!sync_trig) begin
            state_r <= S_SET;
          end else if (tmo_tc_s) begin
            // Give up waiting for release so the handshake cannot hang.
            tmo_err <= 1'b1;
            state_r <= S_SET;
          end else begin
            state_r <= S_ACK;
          end
        end
        S_SET: begin
          if (set_tc_s) begin
            wr_addr <= '0;
            state_r <= S_CAP;
          end else begin
            state_r <= S_SET;
          end
        end
        S_CAP: begin
          if (din_valid) begin
            wr_en   <= 1'b1;
            wr_data <= din;
            wr_addr <= AW'(cap_cnt_r);
            if (cap_tc_s) begin
              cap_done <= 1'b1;
              state_r  <= S_DONE;
            end else begin
              state_r  <= S_CAP;
            end
          end else begin
            state_r <= S_CAP;
          end
        end
        S_DONE: begin
          sync_cnt  <= sync_cnt + SYNC_CNT_W'(1'b1);
          syncr_rdy <= 1'b1;
          state_r   <= S_RDY;
        end
        default: begin
          syncr_rdy <= 1'b0;
          state_r   <= S_INIT;
        end
      endcase
    end
  end

endmodule
